// File: rtl/sad_min_select.sv
// sad_min_select: tracks the minimum block SAD and its motion vector over a raster-order search window
//   clk       in  rising-edge clock
//   rst       in  synchronous active-high reset
//   start     in  begin a new search (honoured only when idle)
//   sad_valid in  sad carries the next candidate's SAD this cycle
//   sad       in  unsigned candidate SAD
//   busy      out high while a search is in progress
//   done      out one-cycle pulse when best_* become final
//   best_sad  out minimum SAD found so far
//   best_mvx  out signed x of best candidate
//   best_mvy  out signed y of best candidate
module sad_min_select #(
    parameter int SAD_W = 14,
    parameter int RANGE = 2,
    parameter int MV_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sad_valid,
    input  logic [SAD_W-1:0] sad,
    output logic             busy,
    output logic             done,
    output logic [SAD_W-1:0] best_sad,
    output logic [MV_W-1:0]  best_mvx,
    output logic [MV_W-1:0]  best_mvy
);
    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic signed [MV_W-1:0] MV_MAX = MV_W'(RANGE);
    localparam logic signed [MV_W-1:0] MV_MIN = -MV_MAX;

    state_t                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [SAD_W-1:0]        best_sad_q, best_sad_d;
    logic [MV_W-1:0]         best_mvx_q, best_mvx_d;
    logic [MV_W-1:0]         best_mvy_q, best_mvy_d;
    logic signed [MV_W-1:0]  x_q, x_d;
    logic signed [MV_W-1:0]  y_q, y_d;
    logic                    first, last, better;

    // The counters sit at (-R,-R) exactly when candidate 0 is pending.
    assign first  = (x_q == MV_MIN) && (y_q == MV_MIN);
    assign last   = (x_q == MV_MAX) && (y_q == MV_MAX);
    assign better = first || (sad < best_sad_q);

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        best_sad_d = best_sad_q;
        best_mvx_d = best_mvx_q;
        best_mvy_d = best_mvy_q;
        x_d        = x_q;
        y_d        = y_q;
        if (state_q == IDLE) begin
            if (start) begin
                state_d    = SCAN;
                busy_d     = 1'b1;
                best_sad_d = '1;
                x_d        = MV_MIN;
                y_d        = MV_MIN;
            end
        end else if (sad_valid) begin
            if (better) begin
                best_sad_d = sad;
                best_mvx_d = x_q;
                best_mvy_d = y_q;
            end
            if (last) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                x_d     = MV_MIN;
                y_d     = MV_MIN;
            end else begin
                x_d = (x_q == MV_MAX) ? MV_MIN : x_q + MV_W'(1);
                y_d = (x_q == MV_MAX) ? y_q + MV_W'(1) : y_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            best_sad_q <= '0;
            best_mvx_q <= '0;
            best_mvy_q <= '0;
            x_q        <= MV_MIN;
            y_q        <= MV_MIN;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            best_sad_q <= best_sad_d;
            best_mvx_q <= best_mvx_d;
            best_mvy_q <= best_mvy_d;
            x_q        <= x_d;
            y_q        <= y_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign best_sad = best_sad_q;
    assign best_mvx = best_mvx_q;
    assign best_mvy = best_mvy_q;
endmodule

// File: tb/tb_sad_min_select.sv
// tb_sad_min_select: scoreboard bench for sad_min_select with directed search vectors
module tb_sad_min_select;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sad_valid = 1'b0;
    logic [13:0] sad = '0;
    logic        busy, done;
    logic [13:0] best_sad;
    logic [3:0]  best_mvx, best_mvy;

    typedef struct {int s; int mx; int my;} exp_t;
    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    sad_min_select dut (
        .clk(clk), .rst(rst), .start(start), .sad_valid(sad_valid), .sad(sad),
        .busy(busy), .done(done), .best_sad(best_sad), .best_mvx(best_mvx), .best_mvy(best_mvy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("best_sad", int'(best_sad), e.s);
                chk("best_mvx", int'($signed(best_mvx)), e.mx);
                chk("best_mvy", int'($signed(best_mvy)), e.my);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input int v);
        sad_valid = 1'b1;
        sad = 14'(v);
        @(posedge clk); #1;
        sad_valid = 1'b0;
    endtask

    task automatic expect_result(input int s, input int mx, input int my);
        exp_t e;
        e.s = s; e.mx = mx; e.my = my;
        exp_q.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_sad"}, int'(best_sad), 0);
        chk({tag, "_mvx"}, int'(best_mvx), 0);
        chk({tag, "_mvy"}, int'(best_mvy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("reset");

        // T1: min 300 at k=17 -> (0,+1); done one cycle after last accept
        expect_result(300, 0, 1);
        pulse_start();
        chk("t1_busy", int'(busy), 1);
        for (int k = 0; k < 25; k++) send(k == 17 ? 300 : 1000);
        chk("t1_done_timing", int'(done), 1);
        chk("t1_busy_end", int'(busy), 0);
        @(posedge clk); #1;
        chk("t1_done_cleared", int'(done), 0);

        // T2: tie at k=3 and k=20, earlier wins -> (+1,-2)
        expect_result(500, 1, -2);
        pulse_start();
        for (int k = 0; k < 25; k++) send((k == 3 || k == 20) ? 500 : 900);
        @(posedge clk); #1;

        // T3: all max -> candidate 0 retained
        expect_result(16383, -2, -2);
        pulse_start();
        for (int k = 0; k < 25; k++) send(16383);
        @(posedge clk); #1;

        // T4: T1 data with gaps and ignored mid-scan starts
        expect_result(300, 0, 1);
        pulse_start();
        for (int k = 0; k < 25; k++) begin
            int g;
            g = int'($urandom_range(0, 3));
            for (int i = 0; i < g; i++) begin
                start = (k % 4 == 1);
                @(posedge clk); #1;
                start = 1'b0;
                chk("t4_busy_gap", int'(busy), 1);
            end
            send(k == 17 ? 300 : 1000);
            if (k < 24) chk("t4_busy_scan", int'(busy), 1);
        end
        chk("t4_done", int'(done), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_idle", int'(busy), 0);

        // T5: abort after 10 candidates, then decreasing SADs -> (+2,+2)
        pulse_start();
        for (int k = 0; k < 10; k++) send(100 + k);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero("t5_abort");
        repeat (2) @(posedge clk);
        #1;
        chk("t5_no_done", int'(done), 0);
        expect_result(0, 2, 2);
        pulse_start();
        for (int k = 0; k < 25; k++) send(24 - k);
        @(posedge clk); #1;

        // T6: restart in the done cycle; second search min 7 at k=0
        expect_result(10, 0, 0);
        pulse_start();
        for (int k = 0; k < 25; k++) send(k == 12 ? 10 : 50);
        chk("t6_done_first", int'(done), 1);
        expect_result(7, -2, -2);
        pulse_start();
        chk("t6_busy_again", int'(busy), 1);
        for (int k = 0; k < 25; k++) send(k == 0 ? 7 : 100);
        chk("t6_done_second", int'(done), 1);
        repeat (3) @(posedge clk);
        #1;

        chk("pending_results", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
